sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, default 8: sprite ROM data width in bits.
REQ-002 Parameter RAM_ADDR_BITS, default 14: sprite ROM address width (16K entries).
REQ-003 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-004 Parameter LEN_BITS, default 5: burst length field width; encoded as length-1, so bursts are 1..32 reads.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port req, input, NUM_REQ: per-requester burst request; held until the matching gnt bit is seen.
REQ-008 Port req_addr, input, NUM_REQ*RAM_ADDR_BITS: packed burst start addresses, requester i at slice i.
REQ-009 Port req_len, input, NUM_REQ*LEN_BITS: packed burst lengths minus one.
REQ-010 Port gnt, output, NUM_REQ: one-hot, one-cycle pulse marking acceptance of a burst.
REQ-011 Port busy, output, 1: high while a burst is issuing.
REQ-012 Port rom_en, output, 1: sprite ROM read enable.
REQ-013 Port rom_addr, output, RAM_ADDR_BITS: sprite ROM read address.
REQ-014 Port rom_data, input, RAM_WIDTH: registered ROM read data, valid one cycle after rom_en.
REQ-015 Ports out_valid (1), out_data (RAM_WIDTH), out_id (clog2(NUM_REQ)), out_last (1), all outputs: returned pixel stream with its owner and end-of-burst flag.

Function
REQ-016 FSM states SHALL be IDLE and BURST only.
REQ-017 In IDLE with any req bit high at a clock edge, the arbiter SHALL select the first set bit searching upward from rr_ptr with wrap-around, latch its address and length, and enter BURST.
REQ-018 In the cycle after that edge, gnt SHALL be high for the winner only, busy=1, rom_en=1, rom_addr=latched start address.
REQ-019 In BURST, rom_addr SHALL increment by 1 each cycle, modulo 2**RAM_ADDR_BITS (0x3FFF wraps to 0x0000).
REQ-020 A burst SHALL issue exactly len+1 consecutive reads; after the last read the FSM SHALL return to IDLE, giving exactly one idle cycle (rom_en=0) between bursts.
REQ-021 rr_ptr SHALL update to (winner+1) mod NUM_REQ on each grant; a requester SHALL never wait more than NUM_REQ-1 bursts.
REQ-022 req changes during BURST SHALL be ignored; a req dropped before its grant is discarded silently.
REQ-023 out_valid, out_id and out_last SHALL be rom_en, the burst owner and the last-read flag delayed by one register; out_data SHALL be rom_data passed through combinationally.
REQ-024 out_last SHALL be high on exactly one out_valid beat per burst; for len=0 that beat is also the first.
REQ-025 Requests arriving in the idle gap cycle SHALL be arbitrated at that cycle's edge like any other IDLE request.

Reset
REQ-026 While rst_n=0: state=IDLE, rr_ptr=0, gnt=0, busy=0, rom_en=0, rom_addr=0, out_valid=0, out_id=0, out_last=0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst immediately; no out_valid beat for it appears after reset release.
REQ-028 The first grant after reset SHALL favour requester 0 when multiple req bits are set.

Structure
REQ-029 RAM_WIDTH, RAM_ADDR_BITS and the state encoding SHALL live in a shared sprite package also used by sprite1 and the renderer.
REQ-030 The round-robin priority picker SHALL be a sub-module rr_pick (inputs req, ptr; output one-hot winner plus index).

Verification
REQ-031 Single request: req[2]=1, addr 0x0100, len 3 -> gnt=0b0100 one cycle; rom_addr 0x100..0x103; four out_valid beats with out_id=2, out_last on the fourth.
REQ-032 All four requesting continuously from reset, len 0 each -> grant order 0,1,2,3,0; one idle cycle between bursts.
REQ-033 Wrap: addr 0x3FFE, len 2 -> rom_addr 0x3FFE, 0x3FFF, 0x0000.
REQ-034 Max length: len 31 -> exactly 32 consecutive rom_en cycles and 32 out_valid beats, busy high for 32 cycles.
REQ-035 Reset mid-burst: rst_n low during 3rd read of a len 7 burst -> all outputs 0 at once; no further out_valid; next req[1] granted normally.
REQ-036 Requests during BURST: req[3] raised mid-burst of requester 1 -> ignored until IDLE, then granted exactly once.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared sprite definitions: ROM geometry and arbiter state encoding.
// Also imported by sprite1 and the renderer so all agree on ROM width/depth.
package sprite_rom_arbiter_pkg;

    localparam int SPRITE_RAM_WIDTH     = 8;
    localparam int SPRITE_RAM_ADDR_BITS = 14;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin priority picker: first set request searching upward from ptr,
// wrapping at N. Returns the winner one-hot, its index and a found flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          found
);

    logic [IW-1:0] j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = j;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM burst arbiter: round-robin grants of 1..2**LEN_BITS sequential
// reads, with the returned pixel stream tagged by owner and end-of-burst.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no read issued; any pending req is arbitrated at the edge
//   ST_BURST | one ROM read per cycle, cnt_q reads remaining after this one
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int  RAM_WIDTH     = SPRITE_RAM_WIDTH,
    parameter int  RAM_ADDR_BITS = SPRITE_RAM_ADDR_BITS,
    parameter int  NUM_REQ       = 4,
    parameter int  LEN_BITS      = 5,
    localparam int IW            = idx_bits(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*RAM_ADDR_BITS-1:0] req_addr,
    input  logic [NUM_REQ*LEN_BITS-1:0]   req_len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          rom_en,
    output logic [RAM_ADDR_BITS-1:0]      rom_addr,
    input  logic [RAM_WIDTH-1:0]          rom_data,
    output logic                          out_valid,
    output logic [RAM_WIDTH-1:0]          out_data,
    output logic [IW-1:0]                 out_id,
    output logic                          out_last
);

    arb_state_e               state_q, state_d;
    logic [NUM_REQ-1:0]       gnt_q;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]      cnt_q;
    logic [IW-1:0]            owner_q;
    logic [IW-1:0]            rr_q;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic [IW-1:0]            out_id_q;

    logic [NUM_REQ-1:0]       win_oh;
    logic [IW-1:0]            win_idx;
    logic                     found;
    logic [RAM_ADDR_BITS-1:0] sel_addr;
    logic [LEN_BITS-1:0]      sel_len;
    logic [IW-1:0]            rr_next;
    logic                     burst_last;
    logic                     accept;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .found   (found)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_addr = req_addr[i*RAM_ADDR_BITS +: RAM_ADDR_BITS];
                sel_len  = req_len[i*LEN_BITS +: LEN_BITS];
            end
        end
    end

    assign rr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
    assign accept  = (state_q == ST_IDLE) && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (found)         state_d = ST_BURST;
            ST_BURST: if (cnt_q == '0)   state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        rom_en     = 1'b0;
        burst_last = 1'b0;
        if (state_q == ST_BURST) begin
            busy       = 1'b1;
            rom_en     = 1'b1;
            burst_last = (cnt_q == '0);
        end
    end

    // Burst datapath; req is only sampled while idle, so mid-burst changes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            owner_q     <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            gnt_q       <= '0;
            out_valid_q <= rom_en;
            out_last_q  <= burst_last;
            out_id_q    <= owner_q;
            if (accept) begin
                gnt_q   <= win_oh;
                addr_q  <= sel_addr;
                cnt_q   <= sel_len;
                owner_q <= win_idx;
                rr_q    <= rr_next;
            end else if ((state_q == ST_BURST) && (cnt_q != '0)) begin
                addr_q <= addr_q + RAM_ADDR_BITS'(1);
                cnt_q  <= cnt_q - LEN_BITS'(1);
            end
        end
    end

    assign gnt       = gnt_q;
    assign rom_addr  = addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;
    assign out_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: reset, single/wrap/max bursts,
// round-robin order, requests during a burst and reset mid-burst.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int LW = 5;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            out_last;

    int passed = 0;
    int total  = 0;

    sprite_rom_arbiter #(
        .RAM_WIDTH     (DW),
        .RAM_ADDR_BITS (AW),
        .NUM_REQ       (N),
        .LEN_BITS      (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .gnt       (gnt),
        .busy      (busy),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},       32'(gnt),       0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_rom_en"},    32'(rom_en),    0);
        check({tag, "_rom_addr"},  32'(rom_addr),  0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_id"},    32'(out_id),    0);
        check({tag, "_out_last"},  32'(out_last),  0);
    endtask

    // Single-requester burst from an idle cycle; ends in the idle gap cycle.
    task automatic run_burst(input string tag, input int who, input int addr, input int len);
        req_addr[who*AW +: AW] = AW'(addr);
        req_len[who*LW +: LW]  = LW'(len);
        req[who] = 1'b1;
        tick();
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << who));
        req[who] = 1'b0;
        for (int t = 0; t <= len + 1; t++) begin
            if (t > 0) begin
                tick();
                check({tag, "_gnt_clear"}, 32'(gnt), 0);
            end
            check({tag, "_rom_en"}, 32'(rom_en), (t <= len) ? 1 : 0);
            check({tag, "_busy"},   32'(busy),   (t <= len) ? 1 : 0);
            if (t <= len)
                check({tag, "_rom_addr"}, 32'(rom_addr), 32'((addr + t) & 'h3FFF));
            check({tag, "_out_valid"}, 32'(out_valid), (t >= 1) ? 1 : 0);
            if (t >= 1) begin
                check({tag, "_out_id"},   32'(out_id),   32'(who));
                check({tag, "_out_last"}, 32'(out_last), (t == len + 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int k;
        int cyc;
        int prev;
        int idx;
        int g3_cnt;
        int g3_cyc;
        int other_cnt;

        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        rom_data = 8'h5A;

        // Reset state
        tick();
        check_all_zero("reset");
        check("passthru_5a", 32'(out_data), 32'h5A);
        rom_data = 8'hC3;
        #1;
        check("passthru_c3", 32'(out_data), 32'hC3);

        // All four requesting from reset, len 0: order 0,1,2,3,0 every 2 cycles
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(16 * i);
        req = 4'hF;
        tick();
        rst_n = 1'b1;
        k = 0; cyc = 0; prev = 0;
        while (k < 5 && cyc < 20) begin
            tick();
            cyc++;
            if (cyc <= 9) check("rr_rom_en", 32'(rom_en), 32'(cyc % 2));
            if (gnt != '0) begin
                idx = 0;
                for (int i = N - 1; i >= 0; i--) if (gnt[i]) idx = i;
                check("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
                check("rr_spacing", 32'(cyc - prev), (k == 0) ? 1 : 2);
                prev = cyc;
                k++;
            end
        end
        check("rr_grant_count", 32'(k), 5);
        req = '0;
        tick();
        tick();

        run_burst("single", 2, 'h0100, 3);
        run_burst("wrap",   0, 'h3FFE, 2);
        run_burst("maxlen", 3, 'h0200, 31);

        // req[3] raised mid-burst of requester 1: waits for IDLE, granted once
        req_addr[1*AW +: AW] = AW'('h0300);
        req_len[1*LW +: LW]  = LW'(5);
        req_addr[3*AW +: AW] = AW'('h0400);
        req_len[3*LW +: LW]  = LW'(0);
        req[1] = 1'b1;
        tick();
        check("mid_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        g3_cnt = 0; g3_cyc = -1; other_cnt = 0;
        for (int t = 1; t <= 15; t++) begin
            if (t == 2) req[3] = 1'b1;
            tick();
            if (gnt[3]) begin
                g3_cnt++;
                if (g3_cyc < 0) g3_cyc = t;
                req[3] = 1'b0;
                check("mid_addr3", 32'(rom_addr), 32'h0400);
            end
            if (gnt[2:0] != '0) other_cnt++;
        end
        check("mid_g3_count", 32'(g3_cnt), 1);
        check("mid_g3_cycle", 32'(g3_cyc), 7);
        check("mid_other_gnt", 32'(other_cnt), 0);

        // Reset during the third read of a len 7 burst
        req_addr[1*AW +: AW] = AW'('h0040);
        req_len[1*LW +: LW]  = LW'(7);
        req[1] = 1'b1;
        tick();
        check("rst_gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        tick();
        tick();
        check("rst_third_addr", 32'(rom_addr), 32'h0042);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("post_rst_valid", 32'(out_valid), 0);
            check("post_rst_rom_en", 32'(rom_en), 0);
        end
        run_burst("after_rst", 1, 'h0080, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
